// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path (and the future transmitter):
//   - rx_state_t      : receiver FSM state encoding
//   - DEFAULT_OVERSAMPLE : default oversampling ratio
//   - calc_div()      : clocks per oversample tick, truncated, minimum 1
//   - parity_of()     : even-parity reduction over up to 8 data bits
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    localparam int DEFAULT_OVERSAMPLE = 16;

    // Clocks per oversample tick; never below one so the tick generator stays alive.
    function automatic int calc_div(input int clk_freq, input int baud_rate, input int oversample);
        int div_v;
        div_v = clk_freq / (baud_rate * oversample);
        if (div_v < 1) begin
            div_v = 1;
        end else begin
            div_v = div_v;
        end
        return div_v;
    endfunction

    // XOR of all data bits; callers zero-extend narrower words.
    function automatic logic parity_of(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Oversample tick generator: registered one-clock tick every DIV clocks.
// A restart pulse zeroes the counter so tick phase aligns to an external event.
// Ports:
//   clk     in  system clock
//   reset_n in  asynchronous active-low reset
//   restart in  synchronous counter restart
//   tick    out one-clock pulse every DIV clocks
// -----------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_r;

    // Divider counter with registered tick output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= '0;
            tick  <= 1'b0;
        end else if (restart) begin
            cnt_r <= '0;
            tick  <= 1'b0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
            tick  <= 1'b1;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receive deframer fed by an already-synchronized RX line. Validates the
// start bit at mid-bit, samples DATA_BITS data bits LSB-first, checks the stop
// bit and emits a one-cycle rx_valid or frame_err strobe per frame.
// Optional feature macro: UART_RX_PARITY_EN (inserts an even-parity bit).
// Ports:
//   clk        in  system clock
//   reset_n    in  asynchronous active-low reset
//   rx_sync    in  synchronized RX line, idle high
//   rx_data    out last correctly framed byte (LSB = first bit received)
//   rx_valid   out one-cycle strobe, rx_data is new
//   frame_err  out one-cycle strobe, stop bit sampled low
//   parity_err out one-cycle strobe, parity mismatch (0 when feature disabled)
//   busy       out high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx_sync,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int DIV  = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam int BC_W = $clog2(DATA_BITS + 1);
    localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

    rx_state_t            state_r, state_nx_s;
    logic [OS_W-1:0]      os_cnt_r, os_cnt_nx_s;
    logic [BC_W-1:0]      bit_cnt_r, bit_cnt_nx_s;
    logic [DATA_BITS-1:0] shift_r, shift_nx_s;
    logic [DATA_BITS-1:0] data_nx_s;
    logic                 valid_nx_s, ferr_nx_s, perr_nx_s;
    logic                 restart_s, tick_s;
    logic                 parity_bad_r, parity_bad_nx_s;

    // Tick phase restarts on the start edge so mid-bit sampling is aligned to it.
    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (restart_s),
        .tick    (tick_s)
    );

    // Next-state, counter and strobe logic.
    always_comb begin
        state_nx_s      = state_r;
        os_cnt_nx_s     = os_cnt_r;
        bit_cnt_nx_s    = bit_cnt_r;
        shift_nx_s      = shift_r;
        data_nx_s       = rx_data;
        valid_nx_s      = 1'b0;
        ferr_nx_s       = 1'b0;
        perr_nx_s       = 1'b0;
        restart_s       = 1'b0;
        parity_bad_nx_s = parity_bad_r;

        case (state_r)
            IDLE: begin
                if (!rx_sync) begin
                    state_nx_s      = START;
                    os_cnt_nx_s     = '0;
                    restart_s       = 1'b1;
                    parity_bad_nx_s = 1'b0;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            START: begin
                if (tick_s) begin
                    if (os_cnt_r == OS_MID) begin
                        os_cnt_nx_s  = '0;
                        bit_cnt_nx_s = '0;
                        // A start bit gone high by mid-bit was a glitch.
                        if (!rx_sync) begin
                            state_nx_s = DATA;
                        end else begin
                            state_nx_s = IDLE;
                        end
                    end else begin
                        os_cnt_nx_s = os_cnt_r + OS_W'(1);
                    end
                end else begin
                    os_cnt_nx_s = os_cnt_r;
                end
            end
            DATA: begin
                if (tick_s) begin
                    if (os_cnt_r == OS_LAST) begin
                        os_cnt_nx_s  = '0;
                        shift_nx_s   = {rx_sync, shift_r[DATA_BITS-1:1]};
                        bit_cnt_nx_s = bit_cnt_r + BC_W'(1);
                        if (bit_cnt_r == BC_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_nx_s = PARITY;
`else
                            state_nx_s = STOP;
`endif
                        end else begin
                            state_nx_s = DATA;
                        end
                    end else begin
                        os_cnt_nx_s = os_cnt_r + OS_W'(1);
                    end
                end else begin
                    os_cnt_nx_s = os_cnt_r;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick_s) begin
                    if (os_cnt_r == OS_LAST) begin
                        os_cnt_nx_s     = '0;
                        parity_bad_nx_s = parity_of(8'(shift_r)) ^ rx_sync;
                        state_nx_s      = STOP;
                    end else begin
                        os_cnt_nx_s = os_cnt_r + OS_W'(1);
                    end
                end else begin
                    os_cnt_nx_s = os_cnt_r;
                end
            end
`endif
            STOP: begin
                if (tick_s) begin
                    if (os_cnt_r == OS_LAST) begin
                        os_cnt_nx_s = '0;
                        perr_nx_s   = parity_bad_r;
                        if (rx_sync) begin
                            state_nx_s = IDLE;
                            // A parity failure suppresses delivery of the byte.
                            if (!parity_bad_r) begin
                                valid_nx_s = 1'b1;
                                data_nx_s  = shift_r;
                            end else begin
                                valid_nx_s = 1'b0;
                            end
                        end else begin
                            state_nx_s = BREAK;
                            ferr_nx_s  = 1'b1;
                        end
                    end else begin
                        os_cnt_nx_s = os_cnt_r + OS_W'(1);
                    end
                end else begin
                    os_cnt_nx_s = os_cnt_r;
                end
            end
            BREAK: begin
                // Hold off until the line idles so a stuck-low line cannot retrigger.
                if (rx_sync) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = BREAK;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered output flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            os_cnt_r     <= '0;
            bit_cnt_r    <= '0;
            shift_r      <= '0;
            parity_bad_r <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            frame_err    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            os_cnt_r     <= os_cnt_nx_s;
            bit_cnt_r    <= bit_cnt_nx_s;
            shift_r      <= shift_nx_s;
            parity_bad_r <= parity_bad_nx_s;
            rx_data      <= data_nx_s;
            rx_valid     <= valid_nx_s;
            frame_err    <= ferr_nx_s;
            busy         <= (state_nx_s != IDLE);
        end
    end

`ifdef UART_RX_PARITY_EN
    // Registered parity error strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= perr_nx_s;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed self-checking bench for uart_rx at DIV = 1 (16 clocks per bit).
// A monitor collects rx_valid bytes and error strobes; the main sequence
// drives frames and compares against hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int BIT_CLKS = 16;

    logic       clk;
    logic       reset_n;
    logic       rx_sync;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [7:0] valid_q[$];
    int         ferr_cnt;
    int         perr_cnt;
    int         valid_cyc;
    int         busy_at_valid;
    int         start_cyc;
    logic       busy_held;

    uart_rx #(
        .CLK_FREQ   (1_843_200),
        .BAUD_RATE  (115_200),
        .OVERSAMPLE (16),
        .DATA_BITS  (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx_sync    (rx_sync),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter for latency measurement.
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Output monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (reset_n) begin
            if (rx_valid) begin
                valid_q.push_back(rx_data);
                valid_cyc     = cyc;
                busy_at_valid = int'(busy);
            end
            if (frame_err) begin
                ferr_cnt = ferr_cnt + 1;
            end
            if (parity_err) begin
                perr_cnt = perr_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        valid_q.delete();
        ferr_cnt      = 0;
        perr_cnt      = 0;
        busy_at_valid = -1;
    endtask

    task automatic send_bit(input logic b);
        rx_sync = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i]);
        end
`ifdef UART_RX_PARITY_EN
        send_bit(par);
`else
        if (par) begin
            rx_sync = 1'b1;
        end
`endif
        send_bit(stop);
    endtask

    task automatic expect_bytes(input string tag, input logic [7:0] b0, input int n);
        check({tag, "_count"}, valid_q.size(), n);
        if (valid_q.size() > 0) begin
            check({tag, "_data"}, valid_q[0], b0);
        end else begin
            check({tag, "_data_missing"}, 32'd0, 32'd1);
        end
    endtask

    // Directed test sequence.
    initial begin
        reset_n = 1'b0;
        rx_sync = 1'b1;
        clear_mon();
        valid_cyc = 0;
        repeat (4) @(negedge clk);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_parity_err", parity_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Single 0x55 frame with latency and busy alignment.
        send_frame(8'h55, 1'b0, 1'b1);
        rx_sync = 1'b1;
        repeat (4) @(negedge clk);
        expect_bytes("b55", 8'h55, 1);
        check("b55_ferr", ferr_cnt, 0);
        check("b55_busy_fall", busy_at_valid, 0);
        check("b55_latency", ((valid_cyc - start_cyc) >= 150 && (valid_cyc - start_cyc) <= 158), 1'b1);
        check("b55_idle", busy, 1'b0);
        clear_mon();

        // Back-to-back frames with no idle gap.
        send_frame(8'hA3, 1'b0, 1'b1);
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("b2b_count", valid_q.size(), 3);
        if (valid_q.size() == 3) begin
            check("b2b_0", valid_q[0], 8'hA3);
            check("b2b_1", valid_q[1], 8'h00);
            check("b2b_2", valid_q[2], 8'hFF);
        end else begin
            check("b2b_order", 32'd0, 32'd1);
        end
        check("b2b_ferr", ferr_cnt, 0);
        clear_mon();

        // Glitch shorter than half a bit is rejected.
        rx_sync = 1'b0;
        repeat (3) @(negedge clk);
        rx_sync = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_valid", valid_q.size(), 0);
        check("glitch_ferr", ferr_cnt, 0);
        check("glitch_idle", busy, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        expect_bytes("b3c", 8'h3C, 1);
        clear_mon();

        // Framing error: stop bit low for two bit periods.
        send_frame(8'h81, 1'b0, 1'b0);
        busy_held = 1'b1;
        for (int i = 0; i < BIT_CLKS; i++) begin
            busy_held = busy_held & busy;
            @(negedge clk);
        end
        check("ferr_busy_in_break", busy_held, 1'b1);
        rx_sync = 1'b1;
        repeat (4) @(negedge clk);
        check("ferr_count", ferr_cnt, 1);
        check("ferr_valid", valid_q.size(), 0);
        check("ferr_data_kept", rx_data, 8'h3C);
        check("ferr_idle", busy, 1'b0);
        clear_mon();

        // Reset asserted during data bit 4.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) begin
            send_bit(1'b1);
        end
        rx_sync = 1'b0;
        repeat (8) @(negedge clk);
        check("mid_busy", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check("arst_rx_data", rx_data, 8'h00);
        check("arst_busy", busy, 1'b0);
        check("arst_valid", rx_valid, 1'b0);
        rx_sync = 1'b1;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        clear_mon();
        send_frame(8'h5A, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        expect_bytes("b5a", 8'h5A, 1);
        clear_mon();

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so the parity bit must be 1.
        send_frame(8'h07, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        expect_bytes("par_ok", 8'h07, 1);
        check("par_ok_perr", perr_cnt, 0);
        clear_mon();
        send_frame(8'h07, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("par_bad_perr", perr_cnt, 1);
        check("par_bad_valid", valid_q.size(), 0);
        check("par_bad_ferr", ferr_cnt, 0);
        clear_mon();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receive deframer that sits directly downstream of the 2-FF input synchronizer. It consumes the synchronized RX line and runs an internal oversampling baud-tick generator. It validates the start bit, samples data bits LSB-first at mid-bit and checks the stop bit. For each frame it emits either a one-cycle data-valid strobe with the received byte or a framing-error strobe to the packet/command logic.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 115_200, line rate in bit/s.
- OVERSAMPLE, 16, ticks per bit period; must be even and ≥ 4.
- DATA_BITS, 8, data bits per frame (5..8).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rx_sync  in  1  RX line, already synchronized to clk; idle high.
- rx_data  out  DATA_BITS  last correctly framed byte; LSB = first bit received.
- rx_valid  out  1  one-cycle pulse; rx_data is new on this cycle.
- frame_err  out  1  one-cycle pulse; stop bit sampled low.
- parity_err  out  1  one-cycle pulse; parity mismatch (see Optional Feature).
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset: async assert when reset_n = 0. State = IDLE; rx_data = 0; rx_valid, frame_err, parity_err and busy = 0; all counters = 0.
- Tick generator:
  - DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE), integer truncation, minimum 1.
  - Emits a 1-clk tick every DIV clocks.
  - Counter restarts at 0 on IDLE→START so tick phase aligns to the start edge.
- os_cnt counts ticks within a bit; bit_cnt counts data bits, width clog2(DATA_BITS+1).
- IDLE:
  - rx_sync = 0 on any clk → START, os_cnt = 0.
- START:
  - On the tick where os_cnt reaches OVERSAMPLE/2 − 1 (mid start bit), sample rx_sync.
  - rx_sync = 0 → DATA, os_cnt = 0, bit_cnt = 0.
  - rx_sync = 1 → false start (glitch), return to IDLE with no output pulse.
- DATA:
  - Every OVERSAMPLE ticks (os_cnt = OVERSAMPLE − 1), sample rx_sync into the shift register, MSB-in, so after DATA_BITS samples the first bit is the LSB.
  - bit_cnt++; after the sample where bit_cnt reaches DATA_BITS → STOP (or PARITY when the feature is enabled).
- STOP: sample at os_cnt = OVERSAMPLE − 1.
  - rx_sync = 1: rx_data ← shift register, rx_valid = 1 for exactly 1 clk, → IDLE.
  - rx_sync = 0: frame_err = 1 for 1 clk, rx_data unchanged, → BREAK.
- BREAK:
  - Wait until rx_sync = 1, then → IDLE. Prevents a held-low line from re-triggering START.
- Timing:
  - Latency from the start-bit falling edge to rx_valid ≈ (1.5 + DATA_BITS) bit periods + 1 clk.
  - The next frame's start edge is accepted the cycle after the return to IDLE, so back-to-back frames with one stop bit are received without loss.
- rx_valid, frame_err and parity_err are mutually exclusive within a frame, except as defined for the parity/stop interaction below.
- There is no backpressure. rx_data is held until the next valid frame; the consumer must take it within one frame time.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
  - Defined: a PARITY state is inserted between DATA and STOP. It samples one bit at os_cnt = OVERSAMPLE − 1 and checks even parity (XOR of data bits and parity bit must be 0).
  - Parity mismatch: parity_err pulses 1 clk coincident with the stop-bit decision; rx_valid is suppressed; frame_err is still reported independently.
- Not defined: no PARITY state; parity_err is tied to 0.

Decomposition:
- Package uart_pkg:
  - State encoding: IDLE, START, DATA, PARITY, STOP, BREAK.
  - Default OVERSAMPLE.
  - A DIV computation function, shared with the future uart_tx.
- Sub-module uart_baud_tick:
  - Parameter DIV; ports clk, reset_n, restart, tick.
  - Reused by the transmitter.

Test Plan:
- Byte 0x55: CLK_FREQ = 1_843_200, BAUD_RATE = 115_200 (DIV = 1), drive frame 0x55 with 1 stop bit → rx_valid pulses once, rx_data = 0x55, frame_err = 0, busy falls on the same cycle.
- Back-to-back bytes 0xA3, 0x00, 0xFF with zero idle gap → three rx_valid pulses in order with matching rx_data, no errors.
- Glitch rejection: rx_sync low for 3 ticks (< OVERSAMPLE/2), then high → no rx_valid, no frame_err, state back in IDLE; a following 0x3C frame is received correctly.
- Framing error: frame 0x81 with stop bit held low for 2 bit periods → frame_err pulses once, rx_valid = 0, rx_data keeps its previous value, no new START until rx_sync returns high.
- Reset mid-frame: assert reset_n = 0 during data bit 4 → outputs zero immediately (async); after release a clean 0x5A frame gives rx_data = 0x5A.
- Parity (UART_RX_PARITY_EN defined): send 0x07 with parity bit 1 → rx_valid, rx_data = 0x07. Send 0x07 with parity bit 0 → parity_err = 1, rx_valid = 0.
